// File: rtl/dac_pkg.sv
// dac_pkg: shared widths, stereo pair type and DAC code conversion (rounding when DAC_ROUND_EN is defined)
package dac_pkg;
  localparam int IN_W = 24;
  localparam int OUT_W = 12;
  localparam int MIN_PERIOD = 17;
  localparam logic [OUT_W-1:0] MIDSCALE = 12'h800;
  typedef struct packed {
    logic [IN_W-1:0] left;
    logic [IN_W-1:0] right;
  } pair_t;
  function automatic logic [OUT_W-1:0] to_dac_code(input logic [IN_W-1:0] s);
    logic [IN_W-1:0] v;
`ifdef DAC_ROUND_EN
    v = s + IN_W'(1 << (IN_W - OUT_W - 1));
    v = (!s[IN_W-1] && v[IN_W-1]) ? {1'b0, {(IN_W-1){1'b1}}} : v;
`else
    v = s;
`endif
    return {~v[IN_W-1], v[IN_W-2 -: OUT_W-1]};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count and full/empty flags
module sync_fifo #(
  parameter int W = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic push, pop;
  assign full = count == (AW+1)'(2**AW);
  assign empty = count == '0;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign rd_data = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= wr_data;
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder: FIFO-buffered stereo sample pacer feeding DAC codes; DAC_ROUND_EN selects round-to-nearest
module dac_sample_feeder #(
  parameter int FIFO_AW = 4,
  parameter int IN_W = dac_pkg::IN_W,
  parameter int OUT_W = dac_pkg::OUT_W,
  parameter int MIN_PERIOD = dac_pkg::MIN_PERIOD,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] rate_div,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_left,
  input  logic [IN_W-1:0]  in_right,
  output logic             data_en,
  output logic [OUT_W-1:0] data_left,
  output logic [OUT_W-1:0] data_right,
  output logic [FIFO_AW:0] fifo_level,
  output logic             underrun,
  output logic [7:0]       underrun_count
);
  import dac_pkg::*;
  localparam logic [DIV_W-1:0] MINP = DIV_W'(MIN_PERIOD);
  pair_t head;
  logic empty, full, tick;
  logic [DIV_W-1:0] cnt, per, cur_per;
  sync_fifo #(.W($bits(pair_t)), .AW(FIFO_AW)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(in_valid),
    .wr_data({in_left, in_right}),
    .rd_en(tick),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .count(fifo_level)
  );
  assign in_ready = !full;
  always_comb begin
    cur_per = (cnt == '0) ? ((rate_div < MINP) ? MINP : rate_div) : per;
    tick = enable && (cnt == cur_per - DIV_W'(1));
  end
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      per <= MINP;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
      per <= cur_per;
    end
  always_ff @(posedge clk)
    if (reset) begin
      data_en <= 1'b0;
      underrun <= 1'b0;
      underrun_count <= '0;
      data_left <= MIDSCALE;
      data_right <= MIDSCALE;
    end else begin
      data_en <= tick;
      underrun <= tick && empty;
      if (tick && empty && underrun_count != 8'hFF) underrun_count <= underrun_count + 8'd1;
      if (tick && !empty) begin
        data_left <= to_dac_code(head.left);
        data_right <= to_dac_code(head.right);
      end
    end
endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb_dac_sample_feeder: randomized self-checking bench against a queue-based sample-rate model
module tb_dac_sample_feeder;
  logic clk = 0;
  logic reset = 1;
  logic enable = 0;
  logic [15:0] rate_div = 16'd17;
  logic in_valid = 0;
  logic in_ready;
  logic [23:0] in_left = '0;
  logic [23:0] in_right = '0;
  logic data_en;
  logic [11:0] data_left, data_right;
  logic [4:0] fifo_level;
  logic underrun;
  logic [7:0] underrun_count;
  int checks = 0;
  int failures = 0;
  logic [47:0] q[$];
  logic [11:0] exp_l, exp_r;
  int ucnt, cyc, per;
  dac_sample_feeder dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .rate_div(rate_div),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_left(in_left),
    .in_right(in_right),
    .data_en(data_en),
    .data_left(data_left),
    .data_right(data_right),
    .fifo_level(fifo_level),
    .underrun(underrun),
    .underrun_count(underrun_count)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] model_code(input logic [23:0] s);
    int v;
    v = $signed(s);
`ifdef DAC_ROUND_EN
    v = v + 2048;
    if (v > 8388607) v = 8388607;
`endif
    return 12'((v + 8388608) / 4096);
  endfunction
  task automatic set_rate(input int rd);
    rate_div = 16'(rd);
    per = (rd < 17) ? 17 : rd;
  endtask
  task automatic do_reset(input logic en);
    enable = en;
    in_valid = 0;
    reset = 1;
    @(posedge clk); #1;
    checks++; if (data_en !== 1'b0) begin failures++; $display("FAIL reset_data_en got=%b exp=0", data_en); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    checks++; if (underrun_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", underrun_count); end
    checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if (data_left !== 12'h800 || data_right !== 12'h800) begin failures++; $display("FAIL reset_codes got=%h/%h exp=800/800", data_left, data_right); end
    reset = 0;
    q.delete();
    exp_l = 12'h800;
    exp_r = 12'h800;
    ucnt = 0;
    cyc = 0;
  endtask
  task automatic cycle(input logic en, input logic v, input logic [23:0] l, input logic [23:0] r);
    logic tk, acc, und;
    logic [47:0] pr;
    enable = en;
    in_valid = v;
    in_left = l;
    in_right = r;
    tk = en && (cyc % per == per - 1);
    acc = v && (q.size() < 16);
    und = 0;
    if (tk) begin
      if (q.size() > 0) begin
        pr = q.pop_front();
        exp_l = model_code(pr[47:24]);
        exp_r = model_code(pr[23:0]);
      end else begin
        und = 1;
        if (ucnt < 255) ucnt++;
      end
    end
    if (acc) q.push_back({l, r});
    cyc = en ? cyc + 1 : 0;
    @(posedge clk); #1;
    in_valid = 0;
    checks++; if (data_en !== tk) begin failures++; $display("FAIL data_en cyc=%0d got=%b exp=%b", cyc, data_en, tk); end
    checks++; if (underrun !== und) begin failures++; $display("FAIL underrun cyc=%0d got=%b exp=%b", cyc, underrun, und); end
    checks++; if (data_left !== exp_l) begin failures++; $display("FAIL data_left cyc=%0d got=%h exp=%h", cyc, data_left, exp_l); end
    checks++; if (data_right !== exp_r) begin failures++; $display("FAIL data_right cyc=%0d got=%h exp=%h", cyc, data_right, exp_r); end
    checks++; if (fifo_level !== 5'(q.size())) begin failures++; $display("FAIL fifo_level cyc=%0d got=%0d exp=%0d", cyc, fifo_level, q.size()); end
    checks++; if (in_ready !== (q.size() < 16)) begin failures++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, q.size() < 16); end
    checks++; if (underrun_count !== 8'(ucnt)) begin failures++; $display("FAIL underrun_count cyc=%0d got=%0d exp=%0d", cyc, underrun_count, ucnt); end
  endtask
  task automatic test_reset();
    set_rate(17);
    do_reset(0);
    cycle(0, 0, 24'($urandom), 24'($urandom));
  endtask
  task automatic test_rate100();
    set_rate(100);
    do_reset(0);
    cycle(0, 1, 24'h000000, 24'h000000);
    cycle(0, 1, 24'h7FFFFF, 24'h800000);
    for (int i = 0; i < 100; i++) cycle(1, 0, 24'($urandom), 24'($urandom));
    checks++; if (data_en !== 1'b1 || data_left !== 12'h800 || data_right !== 12'h800) begin failures++; $display("FAIL rate100_first got=%b %h/%h exp=1 800/800", data_en, data_left, data_right); end
    for (int i = 0; i < 100; i++) cycle(1, 0, 24'($urandom), 24'($urandom));
    checks++; if (data_en !== 1'b1 || data_left !== 12'hFFF || data_right !== 12'h000 || underrun_count !== 8'd0) begin failures++; $display("FAIL rate100_second got=%b %h/%h cnt=%0d exp=1 fff/000 cnt=0", data_en, data_left, data_right, underrun_count); end
  endtask
  task automatic test_min_period();
    set_rate(5);
    do_reset(0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 24'($urandom), 24'($urandom));
    for (int i = 0; i < 85; i++) cycle(1, 0, 24'($urandom), 24'($urandom));
    checks++; if (data_en !== 1'b1 || underrun !== 1'b1 || underrun_count !== 8'd1) begin failures++; $display("FAIL min_period_underrun got=%b %b %0d exp=1 1 1", data_en, underrun, underrun_count); end
  endtask
  task automatic test_full();
    set_rate(17);
    do_reset(0);
    for (int i = 0; i < 20; i++) cycle(0, 1, 24'($urandom), 24'($urandom));
    checks++; if (fifo_level !== 5'd16 || in_ready !== 1'b0) begin failures++; $display("FAIL full_level got=%0d ready=%b exp=16 ready=0", fifo_level, in_ready); end
    for (int i = 0; i < 17 * 17; i++) cycle(1, 0, 24'($urandom), 24'($urandom));
  endtask
  task automatic test_saturate();
    set_rate(17);
    do_reset(1);
    for (int i = 0; i < 300 * 17; i++) cycle(1, 0, 24'($urandom), 24'($urandom));
    checks++; if (underrun_count !== 8'd255 || data_en !== 1'b1 || data_left !== 12'h800) begin failures++; $display("FAIL saturate got=%0d en=%b left=%h exp=255 en=1 left=800", underrun_count, data_en, data_left); end
  endtask
  task automatic test_reset_mid();
    set_rate(20);
    do_reset(0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 24'($urandom), 24'($urandom));
    for (int i = 0; i < 43; i++) cycle(1, 0, 24'($urandom), 24'($urandom));
    checks++; if (fifo_level !== 5'd8) begin failures++; $display("FAIL mid_level got=%0d exp=8", fifo_level); end
    do_reset(1);
    cycle(0, 0, 24'($urandom), 24'($urandom));
    for (int i = 0; i < 45; i++) cycle(1, 0, 24'($urandom), 24'($urandom));
  endtask
  task automatic test_round();
    set_rate(17);
    do_reset(0);
    cycle(0, 1, 24'h000800, 24'h7FFFFF);
    cycle(0, 1, 24'h800000, 24'hFFFFFF);
    for (int i = 0; i < 17; i++) cycle(1, 0, 24'($urandom), 24'($urandom));
`ifdef DAC_ROUND_EN
    checks++; if (data_left !== 12'h801 || data_right !== 12'hFFF) begin failures++; $display("FAIL round_codes got=%h/%h exp=801/fff", data_left, data_right); end
`else
    checks++; if (data_left !== 12'h800 || data_right !== 12'hFFF) begin failures++; $display("FAIL trunc_codes got=%h/%h exp=800/fff", data_left, data_right); end
`endif
    for (int i = 0; i < 20; i++) cycle(1, 0, 24'($urandom), 24'($urandom));
  endtask
  task automatic test_back_to_back();
    int rates[5] = '{0, 5, 17, 18, 23};
    for (int t = 0; t < 5; t++) begin
      set_rate(rates[t]);
      do_reset(0);
      for (int i = 0; i < 400; i++)
        cycle($urandom_range(0, 49) != 0, $urandom_range(0, 15) < 3 ? 1'b1 : 1'b0, 24'($urandom), 24'($urandom));
    end
  endtask
  initial begin
    test_reset();
    test_rate100();
    test_min_period();
    test_full();
    test_saturate();
    test_reset_mid();
    test_round();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dac_sample_feeder.md
Name: dac_sample_feeder

Overview:
- Upstream stage of the PMOD DA2 DAC serialiser.
- Buffers stereo host samples (24-bit signed, valid/ready) in a small FIFO and converts them to 12-bit straight-binary DAC codes.
- Issues one-cycle data_en strobes at a programmable sample rate, never faster than one DAC frame.
- Handles FIFO underrun by repeating the last sample and counting the event.

Parameters:
- FIFO_AW, 4, log2 FIFO depth; depth = 16 stereo pairs.
- IN_W, 24, input sample width, two's complement.
- OUT_W, 12, DAC code width.
- MIN_PERIOD, 17, minimum clocks between data_en strobes (one DAC frame plus margin).
- DIV_W, 16, width of rate_div.

Ports:
- clk  in  1  system clock; also the DAC serial clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  pacer run; 0 = no strobes.
- rate_div  in  DIV_W  clocks per output sample.
- in_valid  in  1  input sample pair valid.
- in_ready  out  1  FIFO can accept; equals !full, from registered state.
- in_left  in  IN_W  left sample, signed.
- in_right  in  IN_W  right sample, signed.
- data_en  out  1  one-cycle strobe to the serialiser.
- data_left  out  OUT_W  left DAC code, held between strobes.
- data_right  out  OUT_W  right DAC code, held between strobes.
- fifo_level  out  FIFO_AW+1  current occupancy, 0..16.
- underrun  out  1  one-cycle pulse when a tick finds the FIFO empty.
- underrun_count  out  8  saturating underrun count.

Behaviour:
- Reset values:
  - in_ready=1, data_en=0, underrun=0, underrun_count=0, fifo_level=0.
  - data_left=data_right=12'h800 (midscale).
  - Pacer counter=0; FIFO pointers cleared.
- Reset mid-operation discards FIFO contents; no data_en is issued during reset or in the cycle it deasserts.
- Push: in_valid && in_ready writes one pair. in_ready=0 when level=16; a push attempted while full is ignored.
- Pacer:
  - Effective period P = max(rate_div, MIN_PERIOD); rate_div=0 is treated as MIN_PERIOD.
  - While enable=1, the counter counts 0..P-1. A tick occurs when counter==P-1; the counter then wraps to 0.
  - rate_div is sampled at wrap, so a change takes effect on the next period.
  - enable=0 holds the counter at 0 and suppresses ticks. The first tick occurs P-1 cycles after enable rises.
- On a tick (registered, latency 1: data_en asserts the cycle after the tick):
  - FIFO non-empty: pop the head pair, drive the converted codes, pulse data_en.
  - FIFO empty: data_en still pulses with previous codes held; underrun pulses the same cycle as data_en; underrun_count increments, saturating at 255.
- Simultaneous push and pop in the same cycle: both occur, level unchanged.
- Push into an empty FIFO on the tick cycle is not bypassed; it counts as an underrun.
- Conversion (default, truncation): code = in[IN_W-1 -: OUT_W] with MSB inverted.
  - -8388608 -> 0x000.
  - 0 -> 0x800.
  - +8388607 -> 0xFFF.
- Spacing between consecutive data_en strobes is exactly P clocks.

Optional Feature:
- Macro: DAC_ROUND_EN.
- Defined: round-to-nearest before truncation. Add 1 << (IN_W-OUT_W-1) to the sample, saturate at the positive limit, then apply the MSB flip. Example: +8388607 -> 0xFFF, no wrap; 0x000800 -> 0x801.
- Undefined: plain truncation as above.
- Latency is identical in both builds.

Decomposition:
- Package dac_pkg holds:
  - OUT_W, MIN_PERIOD, MIDSCALE=12'h800;
  - typedef of the stereo pair struct (left/right, IN_W each);
  - function to_dac_code(), with the rounding branch under DAC_ROUND_EN.
- Sub-module sync_fifo: parameterised width/depth, registered count, full/empty flags; instantiated once with width 2*IN_W.
- Pacer and conversion stay in the top module.

Test Plan:
- Reset, enable=1, rate_div=100, push pairs (0,0), (0x7FFFFF, 0x800000) -> data_en every 100 clocks; codes 0x800/0x800, then 0xFFF/0x000; no underrun.
- rate_div=5, push 4 pairs -> strobes spaced exactly 17 clocks; FIFO drains in order; the 5th strobe raises underrun, codes held, count=1.
- Push 20 pairs back-to-back with enable=0 -> in_ready drops after the 16th push; fifo_level=16; pairs 17–20 are not accepted.
- Run empty with rate_div=17 for 300 strobes -> underrun_count saturates at 255; data_en continues at midscale 0x800.
- Assert reset for 1 cycle with level=8 mid-run -> level 0, codes 0x800, no data_en; first strobe P-1 cycles after enable is reasserted.
- DAC_ROUND_EN build: push 0x000800 and 0x7FFFFF -> codes 0x801 and 0xFFF; truncation build gives 0x800 and 0xFFF.
